// File: rtl/vram_load_sched.sv
// -----------------------------------------------------------------------------
// vram_load_sched
//
// Write-side sequencer for the video RAM (write_clk domain). Two requesters
// share the single RAM write port:
//   * copy : streams the image ROM into video RAM, hiding the ROM read latency
//            behind a small valid/address pipe.
//   * fill : writes one constant word to every address to clear the frame.
// Each operation covers addresses 0..DEPTH-1 exactly once and pulses done one
// cycle after its last write. Requests arriving while busy are remembered in
// one pending flag per type (duplicates merge); fill wins arbitration.
//
// Ports
//   write_clk   in   write-side clock
//   rst         in   asynchronous active-low reset
//   start_copy  in   single-cycle request: ROM -> RAM copy
//   start_fill  in   single-cycle request: fill RAM with fill_value
//   fill_value  in   fill word, captured when the fill operation is selected
//   rom_ad      out  ROM read address (holds its last value outside COPY)
//   rom_data    in   ROM read data, valid ROM_LAT cycles after rom_ad
//   ram_ce      out  RAM write enable
//   ram_ad      out  RAM write address (holds when ram_ce=0)
//   ram_data    out  RAM write data    (holds when ram_ce=0)
//   busy        out  an operation is active or pending
//   done        out  one-cycle pulse when an operation completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module vram_load_sched #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 9,
  parameter int DEPTH   = 2048,
  parameter int ROM_LAT = 1
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              start_copy,
  input  logic              start_fill,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_ce,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    COPY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Counters stop here; an operation never wraps its address.
  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                pend_fill_q, pend_fill_d;
  logic                pend_copy_q, pend_copy_d;
  logic [DATA_W-1:0]   fill_reg_q, fill_reg_d;

  // In-flight ROM reads: stage i holds the read issued i+1 cycles ago.
  // The last stage lines up with rom_data for that read.
  logic [ROM_LAT-1:0]  pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]   ad_pipe_q [ROM_LAT];

  // Next values of the registered outputs.
  logic [ADDR_W-1:0]   rom_ad_d;
  logic                ram_ce_d;
  logic [ADDR_W-1:0]   ram_ad_d;
  logic [DATA_W-1:0]   ram_data_d;
  logic                busy_d;
  logic                done_d;

  // High in any cycle where the write port is free for a new operation:
  // from IDLE, or on the completion cycle of the current one.
  logic                arbitrate;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets its default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    pend_fill_d = pend_fill_q | start_fill;
    pend_copy_d = pend_copy_q | start_copy;
    fill_reg_d  = fill_reg_q;
    rom_ad_d    = rom_ad;
    ram_ce_d    = 1'b0;
    ram_ad_d    = ram_ad;
    ram_data_d  = ram_data;
    done_d      = 1'b0;
    arbitrate   = 1'b0;

    // A read enters the pipe on every cycle rom_ad shows a COPY address.
    pipe_vld_d[0] = (state_q == COPY);
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
    end

    // Copy write path: rom_data is valid for the oldest in-flight read.
    // Never overlaps a fill, because a copy only completes once this pipe
    // is empty and a copy only starts after a fill has finished.
    if (pipe_vld_q[ROM_LAT-1]) begin
      ram_ce_d   = 1'b1;
      ram_ad_d   = ad_pipe_q[ROM_LAT-1];
      ram_data_d = rom_data;
    end

    case (state_q)
      IDLE: begin
        arbitrate = 1'b1;
      end

      // ram_ad is the fill address written in the current cycle.
      FILL: begin
        if (ram_ad == LAST_AD) begin
          done_d    = 1'b1;
          arbitrate = 1'b1;
        end else begin
          ram_ce_d   = 1'b1;
          ram_ad_d   = ram_ad + ADDR_W'(1);
          ram_data_d = fill_reg_q;
        end
      end

      // rom_ad is the read issued in the current cycle.
      COPY: begin
        if (rom_ad == LAST_AD) begin
          state_d = DRAIN;
        end else begin
          rom_ad_d = rom_ad + ADDR_W'(1);
        end
      end

      // Wait until the last read has been written; done follows one cycle
      // after that write.
      DRAIN: begin
        if (pipe_vld_q == '0) begin
          done_d    = 1'b1;
          arbitrate = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Selection happens in the same cycle the port frees up, so the next
    // operation's first write/read lands together with done and the two
    // operations run back-to-back. A request of the type being selected in
    // this very cycle merges into the selection.
    if (arbitrate) begin
      if (pend_fill_q || start_fill) begin
        state_d     = FILL;
        pend_fill_d = 1'b0;
        fill_reg_d  = fill_value;
        ram_ce_d    = 1'b1;
        ram_ad_d    = '0;
        ram_data_d  = fill_value;
      end else if (pend_copy_q || start_copy) begin
        state_d     = COPY;
        pend_copy_d = 1'b0;
        rom_ad_d    = '0;
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = pend_fill_d | pend_copy_d | (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_fill_q <= 1'b0;
      pend_copy_q <= 1'b0;
      fill_reg_q  <= '0;
      pipe_vld_q  <= '0;
      rom_ad      <= '0;
      ram_ce      <= 1'b0;
      ram_ad      <= '0;
      ram_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      pend_fill_q <= pend_fill_d;
      pend_copy_q <= pend_copy_d;
      fill_reg_q  <= fill_reg_d;
      pipe_vld_q  <= pipe_vld_d;
      rom_ad      <= rom_ad_d;
      ram_ce      <= ram_ce_d;
      ram_ad      <= ram_ad_d;
      ram_data    <= ram_data_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // NOTE: the address pipe carries no reset; its contents are only consumed
  // when the matching pipe_vld bit is set, and that bit is reset.
  always_ff @(posedge write_clk) begin
    ad_pipe_q[0] <= rom_ad;
    for (int i = 1; i < ROM_LAT; i++) begin
      ad_pipe_q[i] <= ad_pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_vram_load_sched.sv
// -----------------------------------------------------------------------------
// tb_vram_load_sched
//
// Three instances (DEPTH=16, ROM_LAT = 1, 2, 4) share one set of request
// inputs. Each has its own ROM model returning ~addr[8:0] after ROM_LAT
// cycles. A timeline reference model predicts every output of every instance
// each cycle from the operation start times; directed table vectors and
// hand-written sequences cover the multi-cycle corner cases, followed by a
// randomized request phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vram_load_sched;

  localparam int AW = 11;
  localparam int DW = 9;
  localparam int D  = 16;
  localparam int NI = 3;

  localparam int OP_NONE = 0;
  localparam int OP_FILL = 1;
  localparam int OP_COPY = 2;

  logic          write_clk  = 1'b0;
  logic          rst        = 1'b0;
  logic          start_copy = 1'b0;
  logic          start_fill = 1'b0;
  logic [DW-1:0] fill_value = '0;

  logic [AW-1:0] rom_ad_w   [NI];
  logic          ram_ce_w   [NI];
  logic [AW-1:0] ram_ad_w   [NI];
  logic [DW-1:0] ram_data_w [NI];
  logic          busy_w     [NI];
  logic          done_w     [NI];

  always #5 write_clk = ~write_clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      logic [DW-1:0] rom_pipe [LG];
      logic [DW-1:0] rom_data;

      always @(posedge write_clk) begin
        rom_pipe[0] <= ~rom_ad_w[g][DW-1:0];
        for (int s = 1; s < LG; s++) rom_pipe[s] <= rom_pipe[s-1];
      end
      assign rom_data = rom_pipe[LG-1];

      vram_load_sched #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (D),
        .ROM_LAT(LG)
      ) u_dut (
        .write_clk (write_clk),
        .rst       (rst),
        .start_copy(start_copy),
        .start_fill(start_fill),
        .fill_value(fill_value),
        .rom_ad    (rom_ad_w[g]),
        .rom_data  (rom_data),
        .ram_ce    (ram_ce_w[g]),
        .ram_ad    (ram_ad_w[g]),
        .ram_data  (ram_data_w[g]),
        .busy      (busy_w[g]),
        .done      (done_w[g])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each operation is a start edge b; every output is a plain
  // function of (edge - b). Fill writes k at b+k, done at b+D. Copy reads k at
  // b+k, writes k at b+1+L+k, done at b+D+1+L. The next operation starts on
  // the done edge.
  // ---------------------------------------------------------------------------
  int            ecount = 0;
  int            m_op   [NI];
  int            m_b    [NI];
  bit            m_pf   [NI];
  bit            m_pc   [NI];
  logic [DW-1:0] m_fv   [NI];
  logic [AW-1:0] e_rom_ad   [NI];
  logic          e_ce       [NI];
  logic [AW-1:0] e_ram_ad   [NI];
  logic [DW-1:0] e_ram_data [NI];
  logic          e_busy     [NI];
  logic          e_done     [NI];

  task automatic model_reset(input int i);
    m_op[i] = OP_NONE; m_b[i] = 0; m_pf[i] = 0; m_pc[i] = 0; m_fv[i] = '0;
    e_rom_ad[i] = '0; e_ce[i] = 0; e_ram_ad[i] = '0; e_ram_data[i] = '0;
    e_busy[i] = 0; e_done[i] = 0;
  endtask

  task automatic model_step(input int i);
    int lat = lat_of(i);
    int k;
    int w;
    m_pf[i] = m_pf[i] | start_fill;
    m_pc[i] = m_pc[i] | start_copy;
    e_done[i] = 0;
    e_ce[i]   = 0;
    if (m_op[i] != OP_NONE) begin
      int dn = (m_op[i] == OP_FILL) ? m_b[i] + D : m_b[i] + D + 1 + lat;
      if (ecount == dn) begin
        e_done[i] = 1;
        m_op[i]   = OP_NONE;
      end
    end
    if (m_op[i] == OP_NONE) begin
      if (m_pf[i]) begin
        m_op[i] = OP_FILL; m_b[i] = ecount; m_fv[i] = fill_value; m_pf[i] = 0;
      end else if (m_pc[i]) begin
        m_op[i] = OP_COPY; m_b[i] = ecount; m_pc[i] = 0;
      end
    end
    k = ecount - m_b[i];
    if (m_op[i] == OP_FILL && k >= 0 && k < D) begin
      e_ce[i] = 1; e_ram_ad[i] = AW'(k); e_ram_data[i] = m_fv[i];
    end
    if (m_op[i] == OP_COPY) begin
      if (k >= 0 && k < D) e_rom_ad[i] = AW'(k);
      w = k - 1 - lat;
      if (w >= 0 && w < D) begin
        e_ce[i] = 1; e_ram_ad[i] = AW'(w); e_ram_data[i] = ~DW'(w);
      end
    end
    e_busy[i] = m_pf[i] | m_pc[i] | (m_op[i] != OP_NONE);
  endtask

  always @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) model_reset(i);
    end else begin
      ecount++;
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge write_clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d rom_ad", lat_of(i)),   32'(rom_ad_w[i]),   32'(e_rom_ad[i]));
      check($sformatf("L%0d ram_ce", lat_of(i)),   32'(ram_ce_w[i]),   32'(e_ce[i]));
      check($sformatf("L%0d ram_ad", lat_of(i)),   32'(ram_ad_w[i]),   32'(e_ram_ad[i]));
      check($sformatf("L%0d ram_data", lat_of(i)), 32'(ram_data_w[i]), 32'(e_ram_data[i]));
      check($sformatf("L%0d busy", lat_of(i)),     32'(busy_w[i]),     32'(e_busy[i]));
      check($sformatf("L%0d done", lat_of(i)),     32'(done_w[i]),     32'(e_done[i]));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors (offsets j counted in cycles after the request; j=0 is
  // the cycle right after the start pulse)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            fill;
    bit            copy;
    logic [DW-1:0] fv;
    int            inst;
    int            exp_first;  // cycle of first ram_ce
    int            exp_done;   // cycle of done
    logic [DW-1:0] exp_d0;     // data of first write
  } vec_t;

  vec_t vecs [6];

  task automatic pulse(input bit f, input bit c, input logic [DW-1:0] fv);
    @(negedge write_clk);
    start_fill = f; start_copy = c; fill_value = fv;
    @(negedge write_clk);
    start_fill = 0; start_copy = 0;
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    int            first_w  = -1;
    int            done_j   = -1;
    int            n_done   = 0;
    logic [DW-1:0] d0       = '0;
    logic          busy_pre = 1'b0;
    logic          busy_at  = 1'b1;
    pulse(v.fill, v.copy, v.fv);
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge write_clk);
      if (ram_ce_w[v.inst] && first_w < 0) begin
        first_w = j; d0 = ram_data_w[v.inst];
      end
      if (done_w[v.inst]) begin
        n_done++;
        if (done_j < 0) begin done_j = j; busy_at = busy_w[v.inst]; end
      end
      if (j == v.exp_done - 1) busy_pre = busy_w[v.inst];
    end
    check($sformatf("vec%0d first write cycle", n), 32'(first_w), 32'(v.exp_first));
    check($sformatf("vec%0d done cycle", n),        32'(done_j),  32'(v.exp_done));
    check($sformatf("vec%0d done count", n),        32'(n_done),  32'd1);
    check($sformatf("vec%0d first data", n),        32'(d0),      32'(v.exp_d0));
    check($sformatf("vec%0d busy before done", n),  32'(busy_pre), 32'd1);
    check($sformatf("vec%0d busy at done", n),      32'(busy_at),  32'd0);
  endtask

  task automatic async_reset_pulse();
    @(posedge write_clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d ram_ce in reset", lat_of(i)), 32'(ram_ce_w[i]), 32'd0);
      check($sformatf("L%0d busy in reset", lat_of(i)),   32'(busy_w[i]),   32'd0);
      check($sformatf("L%0d done in reset", lat_of(i)),   32'(done_w[i]),   32'd0);
    end
    @(negedge write_clk);
    @(negedge write_clk);
    rst = 1'b1;
  endtask

  initial begin
    int n_done;
    int gap;
    int good;
    int last_done;
    int nwr;
    int first_done;
    logic [AW-1:0] rom_at_done;
    logic [AW-1:0] rom_before;
    logic [AW-1:0] prev_rom;

    vecs[0] = '{1'b1, 1'b0, 9'h1A5, 0, 0, 16, 9'h1A5};
    vecs[1] = '{1'b0, 1'b1, 9'h000, 0, 2, 18, 9'h1FF};
    vecs[2] = '{1'b0, 1'b1, 9'h000, 1, 3, 19, 9'h1FF};
    vecs[3] = '{1'b0, 1'b1, 9'h000, 2, 5, 21, 9'h1FF};
    vecs[4] = '{1'b1, 1'b0, 9'h0F0, 2, 0, 16, 9'h0F0};
    vecs[5] = '{1'b1, 1'b0, 9'h000, 1, 0, 16, 9'h000};

    // Reset state
    repeat (3) @(negedge write_clk);
    rst = 1'b1;
    repeat (2) @(negedge write_clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d idle busy", lat_of(i)), 32'(busy_w[i]), 32'd0);
    end

    for (int n = 0; n < 6; n++) apply_vec(n, vecs[n]);

    // Simultaneous start: fill first, then copy back-to-back.
    pulse(1'b1, 1'b1, 9'h055);
    n_done = 0; gap = 0; good = 0; last_done = -1;
    for (int j = 0; j < 60; j++) begin
      if (j > 0) @(negedge write_clk);
      if (done_w[0]) begin n_done++; last_done = j; end
      if (n_done < 2 && !busy_w[0]) gap++;
      if (j < 16 && ram_ce_w[0] && ram_data_w[0] == 9'h055 && ram_ad_w[0] == AW'(j)) good++;
    end
    check("both: done pulses", 32'(n_done), 32'd2);
    check("both: busy gaps", 32'(gap), 32'd0);
    check("both: fill writes first", 32'(good), 32'd16);
    check("both: final done cycle", 32'(last_done), 32'd34);

    // Three copy requests during a fill, fill_value moving mid-fill.
    pulse(1'b1, 1'b0, 9'h13C);
    n_done = 0; good = 0; nwr = 0;
    for (int j = 0; j < 70; j++) begin
      if (j > 0) @(negedge write_clk);
      if (done_w[0]) n_done++;
      if (ram_ce_w[0]) nwr++;
      if (j < 16 && ram_ce_w[0] && ram_data_w[0] == 9'h13C) good++;
      start_copy = (j == 2 || j == 6 || j == 11);
      fill_value = DW'(j * 7 + 3);
    end
    start_copy = 1'b0;
    check("merge: done pulses", 32'(n_done), 32'd2);
    check("merge: write count", 32'(nwr), 32'd32);
    check("merge: fill data stable", 32'(good), 32'd16);

    // Asynchronous reset in the middle of a copy.
    pulse(1'b0, 1'b1, 9'h000);
    repeat (6) @(negedge write_clk);
    async_reset_pulse();
    nwr = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge write_clk);
      for (int i = 0; i < NI; i++) if (ram_ce_w[i]) nwr++;
    end
    check("reset: residual writes", 32'(nwr), 32'd0);
    apply_vec(0, vecs[0]);

    // ROM_LAT=4 back-to-back copy across the boundary.
    pulse(1'b0, 1'b1, 9'h000);
    nwr = 0; n_done = 0; first_done = -1; rom_at_done = '0; rom_before = '0;
    prev_rom = rom_ad_w[2];
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge write_clk);
      if (ram_ce_w[2]) begin
        if (nwr < 32) check("b2b: ram_ad sequence", 32'(ram_ad_w[2]), 32'(nwr % 16));
        nwr++;
      end
      if (done_w[2]) begin
        n_done++;
        if (n_done == 1) begin
          first_done = j; rom_at_done = rom_ad_w[2]; rom_before = prev_rom;
        end
      end
      prev_rom = rom_ad_w[2];
      start_copy = (j == 5);
    end
    start_copy = 1'b0;
    check("b2b: write count", 32'(nwr), 32'd32);
    check("b2b: done pulses", 32'(n_done), 32'd2);
    check("b2b: first done cycle", 32'(first_done), 32'd21);
    check("b2b: rom_ad at done", 32'(rom_at_done), 32'd0);
    check("b2b: rom_ad before done", 32'(rom_before), 32'd15);

    // Randomized requests against the reference model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge write_clk);
      start_fill = ($urandom_range(0, 29) == 0);
      start_copy = ($urandom_range(0, 29) == 0);
      fill_value = DW'($urandom);
      if (c == 1000) begin
        start_fill = 1'b0; start_copy = 1'b0;
        async_reset_pulse();
      end
    end
    @(negedge write_clk);
    start_fill = 1'b0; start_copy = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge write_clk);
      if (!busy_w[0] && !busy_w[1] && !busy_w[2]) break;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("L%0d final idle", lat_of(i)), 32'(busy_w[i]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
